sobel_frame_sequencer: RTL and testbench

- Frame-level controller for the Sobel coprocessor. It sweeps a 64x64 8-bit image held in the original-image memory and builds each 3x3 window.
- For each window it sequences the convolution unit through its rst/ready handshake, then writes the result into the processed-image memory.
- Provides start/ready/done control toward the host-side load/read logic.

---
 rtl/sobel_pkg.sv | 35 +++
 rtl/sobel_frame_sequencer_if.sv | 31 +++
 rtl/sobel_window_regs.sv | 35 +++
 rtl/sobel_frame_sequencer.sv | 177 +++++++++++++++++
 tb/tb_sobel_frame_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared defaults, FSM state codes and tap helpers for the Sobel frame sequencer.
package sobel_pkg;

    localparam int unsigned SOBEL_IMG_W        = 64;
    localparam int unsigned SOBEL_IMG_H        = 64;
    localparam int unsigned SOBEL_ADDR_W       = 12;
    localparam int unsigned SOBEL_PIX_W        = 8;
    localparam int unsigned SOBEL_CONV_TIMEOUT = 255;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_CLASSIFY   = 3'd1;
    localparam logic [2:0] ST_FETCH      = 3'd2;
    localparam logic [2:0] ST_CONV_START = 3'd3;
    localparam logic [2:0] ST_CONV_WAIT  = 3'd4;
    localparam logic [2:0] ST_WRITE      = 3'd5;
    localparam logic [2:0] ST_DONE       = 3'd6;

    // Fetch cycles: one per issued tap plus one trailing capture cycle.
    localparam logic [3:0] FETCH_LAST_FULL = 4'd9;
    localparam logic [3:0] FETCH_LAST_COL  = 4'd3;

    function automatic logic [1:0] tap_dy(input logic [3:0] k);
        return 2'(k / 4'd3);
    endfunction

    function automatic logic [1:0] tap_dx(input logic [3:0] k);
        return 2'(k % 4'd3);
    endfunction

    // j-th fetched tap: all nine in order, or only the right column (2, 5, 8).
    function automatic logic [3:0] tap_of(input logic [3:0] j, input logic col_only);
        return col_only ? (j + j + j + 4'd2) : j;
    endfunction

endpackage

// File: rtl/sobel_frame_sequencer_if.sv
// Memory-read, convolution-handshake and memory-write bus of the Sobel frame sequencer.
interface sobel_frame_sequencer_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned PIX_W  = 8
);
    logic [ADDR_W-1:0]  rd_addr;
    logic [PIX_W-1:0]   rd_data;
    logic [3*PIX_W-1:0] row1;
    logic [3*PIX_W-1:0] row2;
    logic [3*PIX_W-1:0] row3;
    logic               conv_rst;
    logic               conv_ready;
    logic [PIX_W-1:0]   conv_result;
    logic [ADDR_W-1:0]  wr_addr;
    logic [PIX_W-1:0]   wr_data;
    logic               wr_en;

    modport master (
        output rd_addr, input rd_data,
        output row1, output row2, output row3,
        output conv_rst, input conv_ready, input conv_result,
        output wr_addr, output wr_data, output wr_en
    );

    modport slave (
        input rd_addr, output rd_data,
        input row1, input row2, input row3,
        input conv_rst, output conv_ready, output conv_result,
        input wr_addr, input wr_data, input wr_en
    );
endinterface

// File: rtl/sobel_window_regs.sv
// 3x3 pixel window: per-tap load (tap = row*3 + col) and whole-window column shift-left.
module sobel_window_regs #(
    parameter int unsigned PIX_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load_en,
    input  logic [3:0]         i_load_tap,
    input  logic [PIX_W-1:0]   i_load_data,
    input  logic               i_shift,
    output logic [3*PIX_W-1:0] o_row1,
    output logic [3*PIX_W-1:0] o_row2,
    output logic [3*PIX_W-1:0] o_row3
);
    logic [PIX_W-1:0] r_win [9];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < 9; k++) r_win[k] <= '0;
        end else if (i_shift) begin
            // Right column is left stale; the following fetch overwrites it.
            for (int unsigned r = 0; r < 3; r++) begin
                r_win[3*r]   <= r_win[3*r+1];
                r_win[3*r+1] <= r_win[3*r+2];
            end
        end else if (i_load_en) begin
            for (int unsigned k = 0; k < 9; k++)
                if (i_load_tap == 4'(k)) r_win[k] <= i_load_data;
        end
    end

    assign o_row1 = {r_win[0], r_win[1], r_win[2]};
    assign o_row2 = {r_win[3], r_win[4], r_win[5]};
    assign o_row3 = {r_win[6], r_win[7], r_win[8]};
endmodule

// File: rtl/sobel_frame_sequencer.sv
// Frame sweep controller: builds 3x3 windows, drives the convolution handshake, writes results.
// Optional SOBEL_WINDOW_REUSE_EN: shift the window and fetch only the new right column.
module sobel_frame_sequencer
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W        = SOBEL_IMG_W,
    parameter int unsigned IMG_H        = SOBEL_IMG_H,
    parameter int unsigned ADDR_W       = SOBEL_ADDR_W,
    parameter int unsigned PIX_W        = SOBEL_PIX_W,
    parameter int unsigned CONV_TIMEOUT = SOBEL_CONV_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    output logic                    o_ready,
    output logic                    o_done,
    output logic                    o_err,
    sobel_frame_sequencer_if.master io_bus
);
    localparam int unsigned TMO_W = (CONV_TIMEOUT > 1) ? $clog2(CONV_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(CONV_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] Y_LAST   = ADDR_W'(IMG_H - 1);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_x;
    logic [ADDR_W-1:0] r_y;
    logic [3:0]        r_k;
    logic              r_partial;
    logic [TMO_W-1:0]  r_tmo;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [PIX_W-1:0]  r_wr_data;
    logic              r_err;

    logic [ADDR_W-1:0] w_base;
    logic              w_border;
    logic              w_reuse;
    logic [3:0]        w_issue_j;
    logic [3:0]        w_issue_tap;
    logic [ADDR_W-1:0] w_tap_addr;
    logic [3:0]        w_cap_tap;
    logic [3:0]        w_fetch_last;
    logic              w_load_en;
    logic              w_shift;

`ifdef SOBEL_WINDOW_REUSE_EN
    logic r_prev_interior;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_prev_interior <= 1'b0;
        else if (r_state == ST_IDLE)
            r_prev_interior <= 1'b0;
        else if (r_state == ST_WRITE)
            r_prev_interior <= !w_border && (r_x != X_LAST);
    end

    assign w_reuse = r_prev_interior;
`else
    assign w_reuse = 1'b0;
`endif

    assign w_base   = r_y * W_A + r_x;
    assign w_border = (r_x == '0) || (r_x == X_LAST) || (r_y == '0) || (r_y == Y_LAST);

    // The address for tap j is registered one cycle ahead so it is on rd_addr during FETCH cycle j.
    assign w_issue_j    = (r_state == ST_FETCH) ? r_k + 4'd1 : 4'd0;
    assign w_issue_tap  = tap_of(w_issue_j, (r_state == ST_FETCH) ? r_partial : w_reuse);
    assign w_tap_addr   = w_base + ADDR_W'(tap_dy(w_issue_tap)) * W_A
                        + ADDR_W'(tap_dx(w_issue_tap)) - W_A - ADDR_W'(1);
    assign w_fetch_last = r_partial ? FETCH_LAST_COL : FETCH_LAST_FULL;
    assign w_cap_tap    = tap_of(r_k - 4'd1, r_partial);
    assign w_load_en    = (r_state == ST_FETCH) && (r_k != 4'd0);
    assign w_shift      = (r_state == ST_CLASSIFY) && !w_border && w_reuse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_k       <= '0;
            r_partial <= 1'b0;
            r_tmo     <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_err   <= 1'b0;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_state <= ST_CLASSIFY;
                    end
                end
                ST_CLASSIFY: begin
                    if (w_border) begin
                        r_wr_data <= '0;
                        r_wr_addr <= w_base;
                        r_state   <= ST_WRITE;
                    end else begin
                        r_partial <= w_reuse;
                        r_k       <= '0;
                        r_rd_addr <= w_tap_addr;
                        r_state   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (r_k + 4'd1 < w_fetch_last) r_rd_addr <= w_tap_addr;
                    r_k <= r_k + 4'd1;
                    if (r_k == w_fetch_last) r_state <= ST_CONV_START;
                end
                ST_CONV_START: begin
                    r_tmo   <= '0;
                    r_state <= ST_CONV_WAIT;
                end
                ST_CONV_WAIT: begin
                    if (io_bus.conv_ready) begin
                        r_wr_data <= io_bus.conv_result;
                        r_wr_addr <= w_base;
                        r_state   <= ST_WRITE;
                    end else if (r_tmo == TMO_LAST) begin
                        r_wr_data <= '1;
                        r_wr_addr <= w_base;
                        r_err     <= 1'b1;
                        r_state   <= ST_WRITE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (r_x == X_LAST) begin
                        r_x <= '0;
                        if (r_y == Y_LAST) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_y     <= r_y + 1'b1;
                            r_state <= ST_CLASSIFY;
                        end
                    end else begin
                        r_x     <= r_x + 1'b1;
                        r_state <= ST_CLASSIFY;
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    sobel_window_regs #(
        .PIX_W (PIX_W)
    ) u_window (
        .clk         (clk),
        .rst         (rst),
        .i_load_en   (w_load_en),
        .i_load_tap  (w_cap_tap),
        .i_load_data (io_bus.rd_data),
        .i_shift     (w_shift),
        .o_row1      (io_bus.row1),
        .o_row2      (io_bus.row2),
        .o_row3      (io_bus.row3)
    );

    assign o_ready         = (r_state == ST_IDLE);
    assign o_done          = (r_state == ST_DONE);
    assign o_err           = r_err;
    assign io_bus.conv_rst = (r_state != ST_CONV_WAIT);
    assign io_bus.wr_en    = (r_state == ST_WRITE);
    assign io_bus.rd_addr  = r_rd_addr;
    assign io_bus.wr_addr  = r_wr_addr;
    assign io_bus.wr_data  = r_wr_data;
endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Directed bench for sobel_frame_sequencer on a 4x4 image with pixel[i]=i.
module tb_sobel_frame_sequencer;
    localparam int unsigned W   = 4;
    localparam int unsigned H   = 4;
    localparam int unsigned AW  = 4;
    localparam int unsigned PW  = 8;
    localparam int unsigned TMO = 20;
    localparam logic [15:0] INT_MASK = 16'h0660;   // interior addresses 5, 6, 9, 10
`ifdef SOBEL_WINDOW_REUSE_EN
    localparam int unsigned EXP_CYC = 6;
    localparam int unsigned EXP_CHG = 3;
`else
    localparam int unsigned EXP_CYC = 12;
    localparam int unsigned EXP_CHG = 9;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic ready, done, err;
    logic conv_en;
    int unsigned conv_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;

    sobel_frame_sequencer_if #(.ADDR_W(AW), .PIX_W(PW)) bus ();

    sobel_frame_sequencer #(
        .IMG_W        (W),
        .IMG_H        (H),
        .ADDR_W       (AW),
        .PIX_W        (PW),
        .CONV_TIMEOUT (TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (start),
        .o_ready (ready),
        .o_done  (done),
        .o_err   (err),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.rd_data <= 8'(bus.rd_addr);

    assign bus.conv_result = 8'h5A;

    always @(posedge clk) begin
        if (bus.conv_rst || !conv_en) begin
            conv_cnt       <= 0;
            bus.conv_ready <= 1'b0;
        end else begin
            conv_cnt       <= conv_cnt + 1;
            bus.conv_ready <= (conv_cnt == 2);
        end
    end

    // Observation state, sampled on the falling edge.
    int unsigned wr_cnt, done_cnt, nwin, rows_bad, wcur, wlen5, mcyc, mchg;
    logic        in_wait, meas;
    logic [AW-1:0] wa [32];
    logic [PW-1:0] wd [32];
    logic [AW-1:0] mlast;
    logic [3*PW-1:0] pr1, pr2, pr3;
    logic [3*PW-1:0] s1 [3];
    logic [3*PW-1:0] s2 [3];
    logic [3*PW-1:0] s3 [3];

    always @(negedge clk) begin
        if (bus.wr_en) begin
            if (wr_cnt < 32) begin
                wa[wr_cnt] = bus.wr_addr;
                wd[wr_cnt] = bus.wr_data;
            end
            wr_cnt++;
        end
        if (done) done_cnt++;
        if (!bus.conv_rst) begin
            if (!in_wait) begin
                if (nwin < 3) begin
                    s1[nwin] = bus.row1;
                    s2[nwin] = bus.row2;
                    s3[nwin] = bus.row3;
                end
                nwin++;
            end else if (bus.row1 !== pr1 || bus.row2 !== pr2 || bus.row3 !== pr3) begin
                rows_bad++;
            end
            pr1 = bus.row1; pr2 = bus.row2; pr3 = bus.row3;
            in_wait = 1'b1;
            wcur++;
        end else begin
            in_wait = 1'b0;
        end
        if (meas) begin
            if (!bus.conv_rst) meas = 1'b0;
            else begin
                mcyc++;
                if (bus.rd_addr !== mlast) mchg++;
                mlast = bus.rd_addr;
            end
        end
        if (bus.wr_en) begin
            if (bus.wr_addr == 4'd5) begin
                wlen5 = wcur;
                meas  = 1'b1;
                mcyc  = 0;
                mchg  = 0;
                mlast = bus.rd_addr;
            end
            wcur = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wr_cnt = 0; done_cnt = 0; nwin = 0; rows_bad = 0;
        wcur = 0; wlen5 = 0; mcyc = 0; mchg = 0;
        in_wait = 1'b0; meas = 1'b0; mlast = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned max_cyc, input string tag);
        int unsigned n = 0;
        while (done_cnt == 0 && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; conv_en = 1'b1;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",    32'(ready), 32'd1);
        chk("rst_conv_rst", 32'(bus.conv_rst), 32'd1);
        chk("rst_done",     32'(done), 32'd0);
        chk("rst_err",      32'(err), 32'd0);
        chk("rst_wr_en",    32'(bus.wr_en), 32'd0);
        chk("rst_rd_addr",  32'(bus.rd_addr), 32'd0);
        chk("rst_wr_addr",  32'(bus.wr_addr), 32'd0);
        chk("rst_wr_data",  32'(bus.wr_data), 32'd0);
        chk("rst_row1",     32'(bus.row1), 32'd0);
        chk("rst_row3",     32'(bus.row3), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Frame 1: normal convolution, plus a start pulse while busy.
        clear_mon();
        pulse_start();
        chk("f1_busy_ready", 32'(ready), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        pulse_start();
        wait_done(2000, "f1_done_seen");
        repeat (6) @(posedge clk);
        #1;
        chk("f1_wr_cnt",   32'(wr_cnt), 32'd16);
        chk("f1_done_cnt", 32'(done_cnt), 32'd1);
        chk("f1_ready",    32'(ready), 32'd1);
        chk("f1_err",      32'(err), 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("f1_addr%0d", i), 32'(wa[i]), 32'(i));
            chk($sformatf("f1_data%0d", i), 32'(wd[i]), INT_MASK[i] ? 32'h5A : 32'h00);
        end
        chk("win11_row1", 32'(s1[0]), 32'h000102);
        chk("win11_row2", 32'(s2[0]), 32'h040506);
        chk("win11_row3", 32'(s3[0]), 32'h08090A);
        chk("win21_row1", 32'(s1[1]), 32'h010203);
        chk("win21_row2", 32'(s2[1]), 32'h050607);
        chk("win21_row3", 32'(s3[1]), 32'h090A0B);
        chk("win12_row1", 32'(s1[2]), 32'h040506);
        chk("win12_row3", 32'(s3[2]), 32'h0C0D0E);
        chk("rows_held",  32'(rows_bad), 32'd0);
        chk("px6_cycles", 32'(mcyc), 32'(EXP_CYC));
        chk("px6_rd_chg", 32'(mchg), 32'(EXP_CHG));
        chk("px6_rd_last", 32'(mlast), 32'd11);

        // Frame 2: convolution never answers, every interior pixel times out.
        clear_mon();
        conv_en = 1'b0;
        pulse_start();
        wait_done(3000, "f2_done_seen");
        chk("f2_wr_cnt", 32'(wr_cnt), 32'd16);
        chk("f2_err",    32'(err), 32'd1);
        chk("f2_data5",  32'(wd[5]), 32'hFF);
        chk("f2_data10", 32'(wd[10]), 32'hFF);
        chk("f2_data0",  32'(wd[0]), 32'h00);
        chk("f2_wait5",  32'(wlen5), 32'(TMO));

        // Frame 3: start clears err; reset mid CONV_WAIT of pixel 5.
        clear_mon();
        conv_en = 1'b1;
        pulse_start();
        chk("f3_err_clr", 32'(err), 32'd0);
        begin
            int unsigned n = 0;
            while (bus.conv_rst !== 1'b0 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("f3_in_wait", 32'(bus.conv_rst), 32'd0);
        rst = 1'b1;
        #1;
        chk("f3_rst_ready",    32'(ready), 32'd1);
        chk("f3_rst_conv_rst", 32'(bus.conv_rst), 32'd1);
        chk("f3_rst_wr_en",    32'(bus.wr_en), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("f3_wr_cnt", 32'(wr_cnt), 32'd5);
        chk("f3_done",   32'(done_cnt), 32'd0);
        chk("f3_ready",  32'(ready), 32'd1);

        // Frame 4: restart writes from address 0.
        clear_mon();
        pulse_start();
        wait_done(2000, "f4_done_seen");
        chk("f4_wr_cnt", 32'(wr_cnt), 32'd16);
        chk("f4_addr0",  32'(wa[0]), 32'd0);
        chk("f4_addr15", 32'(wa[15]), 32'd15);
        chk("f4_data5",  32'(wd[5]), 32'h5A);
        chk("f4_data15", 32'(wd[15]), 32'h00);
        chk("f4_err",    32'(err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
